game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Frame-rate game controller for the runner display.
- Sequences intro phases: countdown, logo slide-out, player slide-in.
- In play: tracks player lane from buttons, spawns and advances one coin row, scores hits and counts misses, and ends the game at a miss limit.
- Drives the offset, flip and lane controls of the background/logo/head/coin layer stack. Runs entirely in the pixel-system clock domain, advancing once per frame_tick.

Parameters:
- COUNT_FRAMES, 5, frames spent in COUNT before the logo moves.
- LOGO_STEP, 30, logo_voffset increment per frame in LOGO_OUT.
- LOGO_END, 640, logo_voffset threshold ending LOGO_OUT.
- HEAD_START, 180, head_voffset value at game start.
- HEAD_STEP, 20, head_voffset decrement per frame in PLAYER_IN.
- HEAD_END, 50, head_voffset threshold ending PLAYER_IN.
- LANE_OFS, 100, magnitude of head_hoffset for a side lane.
- COIN_HIT, 40, coin_loc value at which a coin reaches the player row.
- MAX_MISS, 3, misses that end the game.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- frame_tick, in, 1: one-cycle pulse per frame (vsync edge, already in clk domain).
- btn_l, in, 1: left button, synchronized level.
- btn_r, in, 1: right button, synchronized level.
- random, in, 20: free-running RNG value.
- state_o, out, 3: current state encoding (IDLE=0, COUNT=1, LOGO_OUT=2, PLAYER_IN=3, PLAY=4, OVER=5).
- logo_voffset, out, 12: logo layer vertical offset.
- head_voffset, out, 12: head layer vertical offset.
- head_hoffset, out, 12 signed: head layer horizontal offset.
- coin_loc, out, 12 signed: coin travel position; negative means no coin visible.
- coin_lane, out, 2: lane of active coin (0 left, 1 centre, 2 right).
- coin_flip, out, 1: sprite flip bit, latched from random[2] at each coin spawn.
- score, out, 10: hit count, saturating at 1023.
- misses, out, 2: miss count.
- game_over, out, 1: high while in OVER.

Behaviour:
- All registers update on posedge clk only. rst has priority over everything, including a simultaneous frame_tick, and is honoured in any state.
- Reset values:
  - state IDLE; logo_voffset 0; head_voffset HEAD_START; head_hoffset 0.
  - coin_loc -1; coin_lane 1; coin_flip 0; score 0; misses 0; game_over 0.
  - Internal countdown = COUNT_FRAMES.
- State changes and counter updates occur only in cycles where frame_tick=1. Outputs are registered and hold between ticks.
- IDLE: on first tick, load the reset values above and go to COUNT.
- COUNT: on each tick, if countdown>0 decrement it; else go to LOGO_OUT. Total COUNT_FRAMES+1 ticks in COUNT.
- LOGO_OUT: on each tick, if logo_voffset<LOGO_END add LOGO_STEP; else go to PLAYER_IN. Defaults end at 660.
- PLAYER_IN: on each tick, if head_voffset>HEAD_END subtract HEAD_STEP; else go to PLAY. Defaults end at 40.
- PLAY lane, evaluated on each tick:
  - btn_l=1 gives head_hoffset -LANE_OFS, lane 0 (btn_l wins if both pressed).
  - Else btn_r=1 gives +LANE_OFS, lane 2.
  - Else 0, lane 1.
  - head_hoffset is forced to 0 in every state other than PLAY.
- PLAY coin, evaluated on each tick using the lane computed on the same tick:
  - coin_loc<0: spawn. coin_loc<=0; coin_lane<=random[1:0], with value 3 mapped to 1; coin_flip<=random[2].
  - 0<=coin_loc<COIN_HIT: coin_loc<=coin_loc+1.
  - coin_loc==COIN_HIT on a lane match: score<=score+1 (saturating); coin_loc<=-1.
  - coin_loc==COIN_HIT on a mismatch: misses<=misses+1; coin_loc<=-1. If the new misses value equals MAX_MISS, go to OVER and set game_over=1.
  - A respawn therefore takes one extra tick: the coin is invisible for exactly one frame.
- OVER:
  - All outputs frozen except game_over=1.
  - A rising edge of (btn_l|btn_r) sampled on tick go to IDLE; edge detection uses the previous tick's sample.
  - The IDLE pass clears score and misses.
- Illegal state encodings go to IDLE on the next tick.
- Arithmetic: all offsets are 12-bit two's complement. coin_loc never exceeds COIN_HIT. score does not wrap.

Test Plan:
- rst held 3 cycles with frame_tick=1 -> state_o=0, head_voffset=180, coin_loc=-1, score=0 after release. Ticks during rst are ignored.
- From reset, issue ticks -> COUNT for 6 ticks. LOGO_OUT for 23 ticks with logo_voffset ending at 660. PLAYER_IN for 8 ticks with head_voffset ending at 40. state_o=4 on the next tick.
- In PLAY, hold btn_l and btn_r together -> head_hoffset=-100. Release btn_l -> +100 on next tick. Release both -> 0. Leave PLAY -> 0.
- Force random[2:0]=3'b111 at spawn -> coin_lane=1, coin_flip=1. Hold btn centre for 41 ticks -> score=1, coin_loc=-1, then 0 on the next tick.
- Mismatch three coins (random[1:0]=0, no button) -> misses 1, 2, 3; state_o=5 and game_over=1 on the third hit tick. Further ticks leave score unchanged.
- In OVER, hold btn_r across ticks -> exactly one restart. Restart gives state IDLE then COUNT, score=0, misses=0. Assert rst mid-PLAYER_IN -> immediate IDLE and reset values.

Source files
------------

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Frame-rate controller for the runner display. Walks through
//               the intro phases (countdown, logo slide-out, player slide-in),
//               then runs the play loop: player lane from the buttons, a
//               single coin row that spawns, advances and is scored as a hit
//               or a miss, and a game-over state once the miss limit is hit.
//               Every register advances only on cycles where frame_tick=1.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               frame_tick        - one-cycle pulse per video frame
//               btn_l, btn_r      - synchronized button levels
//               random            - free-running RNG value (bits [2:0] used)
//               state_o           - current state encoding
//               logo_voffset      - logo layer vertical offset
//               head_voffset      - head layer vertical offset
//               head_hoffset      - head layer horizontal offset (signed)
//               coin_loc          - coin travel position, negative = hidden
//               coin_lane, coin_flip - coin lane and sprite flip
//               score, misses     - hit and miss counters
//               game_over         - high while in OVER
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int COUNT_FRAMES = 5,
    parameter int LOGO_STEP    = 30,
    parameter int LOGO_END     = 640,
    parameter int HEAD_START   = 180,
    parameter int HEAD_STEP    = 20,
    parameter int HEAD_END     = 50,
    parameter int LANE_OFS     = 100,
    parameter int COIN_HIT     = 40,
    parameter int MAX_MISS     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic [19:0]        random,
    output logic [2:0]         state_o,
    output logic [11:0]        logo_voffset,
    output logic [11:0]        head_voffset,
    output logic signed [11:0] head_hoffset,
    output logic signed [11:0] coin_loc,
    output logic [1:0]         coin_lane,
    output logic               coin_flip,
    output logic [9:0]         score,
    output logic [1:0]         misses,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNT     = 3'd1,
        S_LOGO_OUT  = 3'd2,
        S_PLAYER_IN = 3'd3,
        S_PLAY      = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    localparam logic [15:0]        c_count_frames = 16'(COUNT_FRAMES);
    localparam logic [11:0]        c_logo_step    = 12'(LOGO_STEP);
    localparam logic [11:0]        c_logo_end     = 12'(LOGO_END);
    localparam logic [11:0]        c_head_start   = 12'(HEAD_START);
    localparam logic [11:0]        c_head_step    = 12'(HEAD_STEP);
    localparam logic [11:0]        c_head_end     = 12'(HEAD_END);
    localparam logic signed [11:0] c_lane_ofs     = 12'(LANE_OFS);
    localparam logic signed [11:0] c_coin_hit     = 12'(COIN_HIT);
    localparam logic [1:0]         c_max_miss     = 2'(MAX_MISS);
    localparam logic [9:0]         c_score_max    = 10'h3FF;

    state_t                r_state;
    logic [15:0]           r_count;
    logic [11:0]           r_logo_voffset;
    logic [11:0]           r_head_voffset;
    logic signed [11:0]    r_head_hoffset;
    logic signed [11:0]    r_coin_loc;
    logic [1:0]            r_coin_lane;
    logic                  r_coin_flip;
    logic [9:0]            r_score;
    logic [1:0]            r_misses;
    logic                  r_game_over;
    logic                  r_btn_prev;      // button sample from the previous tick

    logic                  w_btn_any;
    logic [1:0]            w_lane;
    logic signed [11:0]    w_hoffset;
    logic [1:0]            w_spawn_lane;
    logic [1:0]            w_misses_next;
    logic                  w_unused_random;

    // Player lane from the buttons; left wins when both are held.
    always_comb begin
        w_btn_any = btn_l | btn_r;
        w_lane    = 2'd1;
        w_hoffset = '0;
        if (btn_l) begin
            w_lane    = 2'd0;
            w_hoffset = -c_lane_ofs;
        end else if (btn_r) begin
            w_lane    = 2'd2;
            w_hoffset = c_lane_ofs;
        end
    end

    // Only three lanes exist, so the fourth RNG code folds onto the centre.
    assign w_spawn_lane    = (random[1:0] == 2'd3) ? 2'd1 : random[1:0];
    assign w_misses_next   = r_misses + 2'd1;
    assign w_unused_random = ^random[19:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_count        <= c_count_frames;
            r_logo_voffset <= '0;
            r_head_voffset <= c_head_start;
            r_head_hoffset <= '0;
            r_coin_loc     <= -12'sd1;
            r_coin_lane    <= 2'd1;
            r_coin_flip    <= 1'b0;
            r_score        <= '0;
            r_misses       <= '0;
            r_game_over    <= 1'b0;
            r_btn_prev     <= 1'b0;
        end else if (frame_tick) begin
            r_btn_prev     <= w_btn_any;
            // Horizontal offset only follows the lane while playing.
            r_head_hoffset <= '0;
            case (r_state)
                S_IDLE: begin
                    r_count        <= c_count_frames;
                    r_logo_voffset <= '0;
                    r_head_voffset <= c_head_start;
                    r_coin_loc     <= -12'sd1;
                    r_coin_lane    <= 2'd1;
                    r_coin_flip    <= 1'b0;
                    r_score        <= '0;
                    r_misses       <= '0;
                    r_game_over    <= 1'b0;
                    r_state        <= S_COUNT;
                end
                S_COUNT: begin
                    if (r_count != '0) begin
                        r_count <= r_count - 16'd1;
                    end else begin
                        r_state <= S_LOGO_OUT;
                    end
                end
                S_LOGO_OUT: begin
                    if (r_logo_voffset < c_logo_end) begin
                        r_logo_voffset <= r_logo_voffset + c_logo_step;
                    end else begin
                        r_state <= S_PLAYER_IN;
                    end
                end
                S_PLAYER_IN: begin
                    if (r_head_voffset > c_head_end) begin
                        r_head_voffset <= r_head_voffset - c_head_step;
                    end else begin
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    r_head_hoffset <= w_hoffset;
                    if (r_coin_loc < 0) begin
                        // Spawn; the coin was hidden for this one frame.
                        r_coin_loc  <= '0;
                        r_coin_lane <= w_spawn_lane;
                        r_coin_flip <= random[2];
                    end else if (r_coin_loc < c_coin_hit) begin
                        r_coin_loc <= r_coin_loc + 12'sd1;
                    end else if (r_coin_lane == w_lane) begin
                        r_coin_loc <= -12'sd1;
                        if (r_score != c_score_max) begin
                            r_score <= r_score + 10'd1;
                        end
                    end else begin
                        r_coin_loc <= -12'sd1;
                        r_misses   <= w_misses_next;
                        if (w_misses_next == c_max_miss) begin
                            r_state        <= S_OVER;
                            r_game_over    <= 1'b1;
                            r_head_hoffset <= '0;
                        end
                    end
                end
                S_OVER: begin
                    // Restart only on a fresh press, not a button held from play.
                    if (w_btn_any && !r_btn_prev) begin
                        r_state     <= S_IDLE;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign state_o      = r_state;
    assign logo_voffset = r_logo_voffset;
    assign head_voffset = r_head_voffset;
    assign head_hoffset = r_head_hoffset;
    assign coin_loc     = r_coin_loc;
    assign coin_lane    = r_coin_lane;
    assign coin_flip    = r_coin_flip;
    assign score        = r_score;
    assign misses       = r_misses;
    assign game_over    = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed bench for game_sequencer. A table of
//               {ticks, buttons, rng, expected outputs} records walks the
//               intro phases and three coins of play into OVER; hand-written
//               sequences then cover restart from OVER and reset mid-intro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    logic               clk;
    logic               rst;
    logic               frame_tick;
    logic               btn_l;
    logic               btn_r;
    logic [19:0]        random;
    logic [2:0]         state_o;
    logic [11:0]        logo_voffset;
    logic [11:0]        head_voffset;
    logic signed [11:0] head_hoffset;
    logic signed [11:0] coin_loc;
    logic [1:0]         coin_lane;
    logic               coin_flip;
    logic [9:0]         score;
    logic [1:0]         misses;
    logic               game_over;

    int n_cmp;
    int n_err;

    game_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .btn_l        (btn_l),
        .btn_r        (btn_r),
        .random       (random),
        .state_o      (state_o),
        .logo_voffset (logo_voffset),
        .head_voffset (head_voffset),
        .head_hoffset (head_hoffset),
        .coin_loc     (coin_loc),
        .coin_lane    (coin_lane),
        .coin_flip    (coin_flip),
        .score        (score),
        .misses       (misses),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       bl;
        logic       br;
        logic [19:0] rnd;
        int st, logo, hv, hh, coin, lane, flip, sc, mi, go;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int logo,
                             input int hv, input int hh, input int coin,
                             input int lane, input int flip, input int sc,
                             input int mi, input int go);
        chk({tag, ".state"}, int'(state_o), st);
        chk({tag, ".logo_voffset"}, int'(logo_voffset), logo);
        chk({tag, ".head_voffset"}, int'(head_voffset), hv);
        chk({tag, ".head_hoffset"}, int'(head_hoffset), hh);
        chk({tag, ".coin_loc"}, int'(coin_loc), coin);
        chk({tag, ".coin_lane"}, int'(coin_lane), lane);
        chk({tag, ".coin_flip"}, int'(coin_flip), flip);
        chk({tag, ".score"}, int'(score), sc);
        chk({tag, ".misses"}, int'(misses), mi);
        chk({tag, ".game_over"}, int'(game_over), go);
    endtask

    // One frame: frame_tick high across exactly one rising edge, then one
    // idle cycle so outputs must hold between ticks.
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //            n  bl    br    rnd  st logo  hv   hh  coin ln fl sc mi go
        vecs[0]  = '{1,  1'b0, 1'b0, 20'd0, 1,   0, 180,    0, -1, 1, 0, 0, 0, 0};
        vecs[1]  = '{5,  1'b0, 1'b0, 20'd0, 1,   0, 180,    0, -1, 1, 0, 0, 0, 0};
        vecs[2]  = '{1,  1'b0, 1'b0, 20'd0, 2,   0, 180,    0, -1, 1, 0, 0, 0, 0};
        vecs[3]  = '{22, 1'b0, 1'b0, 20'd0, 2, 660, 180,    0, -1, 1, 0, 0, 0, 0};
        vecs[4]  = '{1,  1'b0, 1'b0, 20'd0, 3, 660, 180,    0, -1, 1, 0, 0, 0, 0};
        vecs[5]  = '{7,  1'b0, 1'b0, 20'd0, 3, 660,  40,    0, -1, 1, 0, 0, 0, 0};
        vecs[6]  = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0, -1, 1, 0, 0, 0, 0};
        // spawn with rng 3'b111: lane code 3 folds to centre, flip set
        vecs[7]  = '{1,  1'b1, 1'b1, 20'd7, 4, 660,  40, -100,  0, 1, 1, 0, 0, 0};
        vecs[8]  = '{1,  1'b0, 1'b1, 20'd0, 4, 660,  40,  100,  1, 1, 1, 0, 0, 0};
        vecs[9]  = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0,  2, 1, 1, 0, 0, 0};
        vecs[10] = '{37, 1'b0, 1'b0, 20'd0, 4, 660,  40,    0, 39, 1, 1, 0, 0, 0};
        vecs[11] = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0, 40, 1, 1, 0, 0, 0};
        vecs[12] = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0, -1, 1, 1, 1, 0, 0};
        // three left-lane coins with no button: three misses
        vecs[13] = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0,  0, 0, 0, 1, 0, 0};
        vecs[14] = '{40, 1'b0, 1'b0, 20'd0, 4, 660,  40,    0, 40, 0, 0, 1, 0, 0};
        vecs[15] = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0, -1, 0, 0, 1, 1, 0};
        vecs[16] = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0,  0, 0, 0, 1, 1, 0};
        vecs[17] = '{40, 1'b0, 1'b0, 20'd0, 4, 660,  40,    0, 40, 0, 0, 1, 1, 0};
        vecs[18] = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0, -1, 0, 0, 1, 2, 0};
        vecs[19] = '{1,  1'b0, 1'b0, 20'd0, 4, 660,  40,    0,  0, 0, 0, 1, 2, 0};
        vecs[20] = '{40, 1'b0, 1'b0, 20'd0, 4, 660,  40,    0, 40, 0, 0, 1, 2, 0};
        vecs[21] = '{1,  1'b0, 1'b0, 20'd0, 5, 660,  40,    0, -1, 0, 0, 1, 3, 1};
        vecs[22] = '{2,  1'b0, 1'b0, 20'd0, 5, 660,  40,    0, -1, 0, 0, 1, 3, 1};

        // Reset held with frame_tick high: ticks must be ignored.
        rst        = 1'b1;
        frame_tick = 1'b1;
        btn_l      = 1'b0;
        btn_r      = 1'b0;
        random     = 20'd0;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        check_all("reset", 0, 0, 180, 0, -1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            btn_l  = vecs[i].bl;
            btn_r  = vecs[i].br;
            random = vecs[i].rnd;
            do_ticks(vecs[i].n);
            check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].logo, vecs[i].hv,
                      vecs[i].hh, vecs[i].coin, vecs[i].lane, vecs[i].flip,
                      vecs[i].sc, vecs[i].mi, vecs[i].go);
        end

        // Fresh press of btn_r in OVER restarts exactly once.
        btn_r = 1'b1;
        do_tick();
        check_all("restart_idle", 0, 660, 40, 0, -1, 0, 0, 1, 3, 0);
        do_tick();
        check_all("restart_count", 1, 0, 180, 0, -1, 1, 0, 0, 0, 0);
        do_ticks(3);
        chk("restart_held.state", int'(state_o), 1);
        repeat (4) @(negedge clk);
        chk("no_tick_hold.state", int'(state_o), 1);
        btn_r = 1'b0;

        // Countdown has 2 left: three ticks reach LOGO_OUT.
        do_ticks(3);
        chk("count_done.state", int'(state_o), 2);
        chk("count_done.logo", int'(logo_voffset), 0);
        do_ticks(26);
        chk("mid_player_in.state", int'(state_o), 3);
        chk("mid_player_in.head_voffset", int'(head_voffset), 120);
        chk("mid_player_in.logo", int'(logo_voffset), 660);

        // Reset mid-PLAYER_IN wins over a simultaneous tick.
        @(negedge clk);
        rst        = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        frame_tick = 1'b0;
        check_all("rst_mid", 0, 0, 180, 0, -1, 1, 0, 0, 0, 0);
        do_tick();
        chk("rst_mid_next.state", int'(state_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
